// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner slice.
// Holds the scanner state encoding, the keypad matrix width, the default
// timing parameters and small combinational helpers on row/column vectors.
package keypad_pkg;

    // Keypad matrix is 4 rows by 4 columns.
    localparam int KP_W = 4;

    // Default clock cycles per column dwell / sample period.
    localparam int KP_SCAN_DIV_DEF = 1000;

    // Default number of consecutive matching samples to accept a press or release.
    localparam int KP_DEBOUNCE_CNT_DEF = 4;

    // Column strobe value after reset.
    localparam logic [KP_W-1:0] KP_COL_RESET = 4'b0001;

    // Scanner states.
    typedef enum logic [1:0] {
        SCAN     = 2'b00,
        DEBOUNCE = 2'b01,
        HELD     = 2'b10,
        RELEASE  = 2'b11
    } kp_state_e;

    // True when exactly one bit of v is set; zero and multi-key (ghost) patterns are rejected.
    function automatic logic is_one_hot(input logic [KP_W-1:0] v);
        logic [KP_W-1:0] v_minus_one;
        v_minus_one = v - 4'b0001;
        return (v != 4'b0000) && ((v & v_minus_one) == 4'b0000);
    endfunction

    // Rotate a column strobe one position toward the MSB, wrapping MSB to LSB.
    function automatic logic [KP_W-1:0] rot_left(input logic [KP_W-1:0] v);
        return {v[KP_W-2:0], v[KP_W-1]};
    endfunction

endpackage

// File: rtl/kp_sync.sv
// Two-flop synchronizer for the raw keypad row lines.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset, clears both flop stages
//   d   - asynchronous input vector
//   q   - synchronized output vector (two clk cycles of latency)
module kp_sync
    import keypad_pkg::*;
#(
    parameter int W = KP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two back-to-back flop stages; the first may go metastable, the second resolves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce.
// Strobes one column at a time, samples the synchronized rows once per dwell
// period, debounces a single-key press and its release, and reports the
// accepted key as one-hot row/column plus a one-cycle key_valid pulse.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   row_in    - raw keypad rows, active-high, asynchronous to clk
//   col_drive - one-hot active-high column strobe to the keypad
//   rows      - one-hot row of the last accepted key
//   cols      - one-hot column of the last accepted key
//   key_valid - single-cycle pulse on each newly accepted press
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = KP_SCAN_DIV_DEF,
    parameter int DEBOUNCE_CNT = KP_DEBOUNCE_CNT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [KP_W-1:0] row_in,
    output logic [KP_W-1:0] col_drive,
    output logic [KP_W-1:0] rows,
    output logic [KP_W-1:0] cols,
    output logic            key_valid
);

    // Dwell counter only needs to reach SCAN_DIV-1; the debounce counters must
    // be able to hold DEBOUNCE_CNT itself, hence the +1.
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [KP_W-1:0]  row_s;
    logic             tick_s;
    logic             row_gone_s;
    logic [CNT_W-1:0] match_inc_s;
    logic [CNT_W-1:0] rel_inc_s;

    kp_state_e        state_r, state_nx;
    logic [DIV_W-1:0] div_cnt_r;
    logic [KP_W-1:0]  col_r, col_nx;
    logic [KP_W-1:0]  cap_row_r, cap_row_nx;
    logic [KP_W-1:0]  cap_col_r, cap_col_nx;
    logic [CNT_W-1:0] match_r, match_nx;
    logic [CNT_W-1:0] rel_r, rel_nx;
    logic [KP_W-1:0]  rows_r, rows_nx;
    logic [KP_W-1:0]  cols_r, cols_nx;
    logic             valid_r, valid_nx;

    kp_sync #(
        .W (KP_W)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (row_s)
    );

    // Free-running dwell counter; its last count is the sample tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end
    end

    assign tick_s = (div_cnt_r == DIV_LAST);

    // Captured key is one-hot, so masking tells whether its row line has dropped.
    assign row_gone_s = ((row_s & cap_row_r) == 4'b0000);

    // Saturating increments keep the counters pinned at the limit.
    assign match_inc_s = (match_r == CNT_LIMIT) ? match_r : (match_r + CNT_ONE);
    assign rel_inc_s   = (rel_r == CNT_LIMIT) ? rel_r : (rel_r + CNT_ONE);

    // Next-state and next-output logic; all decisions happen only on the sample tick.
    always_comb begin
        state_nx   = state_r;
        col_nx     = col_r;
        cap_row_nx = cap_row_r;
        cap_col_nx = cap_col_r;
        match_nx   = match_r;
        rel_nx     = rel_r;
        rows_nx    = rows_r;
        cols_nx    = cols_r;
        valid_nx   = 1'b0;
        if (tick_s) begin
            case (state_r)
                SCAN: begin
                    if (is_one_hot(row_s)) begin
                        cap_row_nx = row_s;
                        cap_col_nx = col_r;
                        match_nx   = CNT_ONE;
                        state_nx   = DEBOUNCE;
                    end else begin
                        col_nx = rot_left(col_r);
                    end
                end
                DEBOUNCE: begin
                    if (row_s == cap_row_r) begin
                        match_nx = match_inc_s;
                        if (match_inc_s == CNT_LIMIT) begin
                            rows_nx  = cap_row_r;
                            cols_nx  = cap_col_r;
                            valid_nx = 1'b1;
                            state_nx = HELD;
                        end else begin
                            state_nx = DEBOUNCE;
                        end
                    end else begin
                        state_nx = SCAN;
                        col_nx   = rot_left(col_r);
                    end
                end
                HELD: begin
                    if (row_gone_s) begin
                        rel_nx   = CNT_ONE;
                        state_nx = RELEASE;
                    end else begin
                        state_nx = HELD;
                    end
                end
                RELEASE: begin
                    if (row_gone_s) begin
                        rel_nx = rel_inc_s;
                        if (rel_inc_s == CNT_LIMIT) begin
                            state_nx = SCAN;
                            col_nx   = rot_left(col_r);
                        end else begin
                            state_nx = RELEASE;
                        end
                    end else begin
                        state_nx = HELD;
                    end
                end
                default: begin
                    state_nx = SCAN;
                    col_nx   = KP_COL_RESET;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // State, capture, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= SCAN;
            col_r     <= KP_COL_RESET;
            cap_row_r <= 4'b0000;
            cap_col_r <= 4'b0000;
            match_r   <= {CNT_W{1'b0}};
            rel_r     <= {CNT_W{1'b0}};
            rows_r    <= 4'b0000;
            cols_r    <= 4'b0000;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_nx;
            col_r     <= col_nx;
            cap_row_r <= cap_row_nx;
            cap_col_r <= cap_col_nx;
            match_r   <= match_nx;
            rel_r     <= rel_nx;
            rows_r    <= rows_nx;
            cols_r    <= cols_nx;
            valid_r   <= valid_nx;
        end
    end

    assign col_drive = col_r;
    assign rows      = rows_r;
    assign cols      = cols_r;
    assign key_valid = valid_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
// A keypad model returns key_row on row_in while col_drive equals key_col;
// force_en overrides it with a raw row pattern.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;

    logic       force_en;
    logic [3:0] force_val;
    logic       key_en;
    logic [3:0] key_row;
    logic [3:0] key_col;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         n;
        logic [3:0] row;
        logic [3:0] col;
        logic       valid;
        logic [3:0] rows;
        logic [3:0] cols;
    } vec_t;

    vec_t tbl[14];

    int         idx;
    int         vcount;
    int         pulses;
    int         first_v;
    int         second_v;
    int         early;
    logic       held_ok;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_drive (col_drive),
        .rows      (rows),
        .cols      (cols),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    assign row_in = force_en ? force_val
                  : ((key_en && (col_drive == key_col)) ? key_row : 4'b0000);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        force_en  = 1'b1;
        force_val = 4'b0000;
        key_en    = 1'b0;
        key_row   = 4'b0000;
        key_col   = 4'b0000;

        // Idle scan: columns rotate every 4 cycles, outputs stay clear.
        tbl[0]  = '{0,  4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000};
        tbl[1]  = '{3,  4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000};
        tbl[2]  = '{4,  4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0000};
        tbl[3]  = '{7,  4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0000};
        tbl[4]  = '{8,  4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b0000};
        tbl[5]  = '{11, 4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b0000};
        tbl[6]  = '{12, 4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b0000};
        tbl[7]  = '{15, 4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b0000};
        tbl[8]  = '{16, 4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000};
        tbl[9]  = '{20, 4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0000};
        tbl[10] = '{24, 4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b0000};
        tbl[11] = '{28, 4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b0000};
        tbl[12] = '{36, 4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0000};
        tbl[13] = '{40, 4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b0000};

        do_reset();
        idx    = 0;
        vcount = 0;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) tick();
            if (key_valid) vcount++;
            if (idx < 14 && tbl[idx].n == n) begin
                chk($sformatf("idle_col_n%0d", n), col_drive, tbl[idx].col);
                chk($sformatf("idle_out_n%0d", n), {key_valid, rows, cols},
                    {tbl[idx].valid, tbl[idx].rows, tbl[idx].cols});
                force_val = tbl[idx].row;
                idx++;
            end
        end
        chk("idle_no_valid", vcount, 0);

        // Bounce: one-hot row for a single sample, then gone.
        do_reset();
        force_en  = 1'b1;
        force_val = 4'b0001;
        vcount    = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (key_valid) vcount++;
            if (n == 4) begin
                chk("bounce_col_held", col_drive, 4'b0001);
                force_val = 4'b0000;
            end
            if (n == 8) chk("bounce_resume_col", col_drive, 4'b0010);
        end
        chk("bounce_no_valid", vcount, 0);

        // Press (row 0010, col 0100), release, second key (row 1000, col 0001), then ghost rows.
        do_reset();
        force_en = 1'b0;
        key_en   = 1'b1;
        key_row  = 4'b0010;
        key_col  = 4'b0100;
        pulses   = 0;
        first_v  = -1;
        second_v = -1;
        held_ok  = 1'b1;
        for (int n = 1; n <= 120; n++) begin
            tick();
            if (key_valid) begin
                pulses++;
                if (first_v < 0) first_v = n;
                else if (second_v < 0) second_v = n;
            end
            if (n >= 8 && n <= 51 && col_drive != 4'b0100) held_ok = 1'b0;
            if (n == 20) chk("press1_rows_cols", {rows, cols}, {4'b0010, 4'b0100});
            if (n == 21) chk("press1_pulse_width", key_valid, 1'b0);
            if (n == 52) begin
                chk("release_rotates", col_drive, 4'b1000);
                chk("release_keeps_rows", {rows, cols}, {4'b0010, 4'b0100});
            end
            if (n == 67) chk("press2_rows_before", rows, 4'b0010);
            if (n == 69) chk("press2_rows_cols", {rows, cols}, {4'b1000, 4'b0001});
            if (n == 80) begin
                chk("two_pulses", pulses, 2);
                chk("press1_latency", first_v, 20);
                chk("press2_latency", second_v, 68);
                chk("col_frozen_held", held_ok, 1'b1);
                key_en    = 1'b0;
                force_en  = 1'b1;
                force_val = 4'b0011;
            end
            if (n == 100) chk("ghost_scan_continues", col_drive, 4'b1000);
            if (n == 120) begin
                chk("ghost_no_valid", pulses, 2);
                chk("ghost_rows_cols", {rows, cols}, {4'b1000, 4'b0001});
            end
            if (n == 40) key_en = 1'b0;
            if (n == 52) begin
                key_row = 4'b1000;
                key_col = 4'b0001;
                key_en  = 1'b1;
            end
        end

        // Reset in the middle of a debounce, then a fresh full debounce, then reset while key_valid is high.
        force_val = 4'b0100;
        repeat (9) tick();
        chk("mid_debounce_no_valid", {key_valid, rows}, {1'b0, 4'b1000});
        rst = 1'b1;
        tick();
        chk("rst_abort_outputs", {col_drive, key_valid, rows, cols},
            {4'b0001, 1'b0, 4'b0000, 4'b0000});
        rst   = 1'b0;
        early = 0;
        for (int m = 1; m <= 12; m++) begin
            tick();
            if (m < 12 && key_valid) early++;
            if (m == 12) chk("fresh_debounce_valid", {key_valid, rows, cols},
                             {1'b1, 4'b0100, 4'b0001});
        end
        chk("no_early_valid", early, 0);
        rst = 1'b1;
        tick();
        chk("rst_during_valid", {col_drive, key_valid, rows, cols},
            {4'b0001, 1'b0, 4'b0000, 4'b0000});
        rst       = 1'b0;
        force_val = 4'b0000;
        vcount    = 0;
        repeat (12) begin
            tick();
            if (key_valid) vcount++;
        end
        chk("post_rst_no_valid", vcount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
